mem_ctl: RTL and testbench

Memory cycle controller and arbiter for the 32K x 12 core memory model. Shares the single memory port between the CPU and the data-break channel (strict break priority), generates the `mem_start` edge, tracks completion via `mem_done_n`, returns read data on `strobe_n`, and performs core-style restore on read-only cycles. Sits between the CPU/break logic and the memory model, fully synchronous to the 100 MHz `clk`.

---
 rtl/pdp8_mem_pkg.sv | 21 ++
 rtl/mem_watchdog.sv | 53 +++++
 rtl/mem_ctl.sv | 198 +++++++++++++++++++
 tb/tb_mem_ctl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_mem_pkg.sv
// Shared types and widths for the core memory cycle controller.
package pdp8_mem_pkg;

   localparam int ADDR_W = 15;
   localparam int WORD_W = 12;
   localparam int TMO_W  = 8;
   localparam int HOLD_W = 7;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_DONE      = 2'd3
   } mem_state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_BRK = 1'b1
   } mem_owner_e;

endpackage

// File: rtl/mem_watchdog.sv
// Bounds the wait for memory completion and keeps a sticky timeout flag.
module mem_watchdog
   import pdp8_mem_pkg::*;
#(
   parameter int TIMEOUT = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear_i,
   input  logic run_i,
   output logic expire_o,
   output logic timeout_err_o
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   logic [TMO_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // The final waiting cycle forces completion on the next edge
   assign expire_o      = run_i && (cnt_q == TMO_LAST);
   assign timeout_err_o = err_q;

   // Count waiting cycles and latch the error once the limit is reached
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (run_i) begin
         cnt_d = cnt_q + TMO_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
      if (expire_o) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Counter and sticky flag; only reset clears the flag
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule

// File: rtl/mem_ctl.sv
// Memory cycle controller: arbitrates CPU vs data break (break first),
// sequences mem_start / done handshake and returns read data.
module mem_ctl
   import pdp8_mem_pkg::*;
#(
   parameter int START_HOLD = 4,
   parameter int TIMEOUT    = 200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_wr,
   input  logic [WORD_W-1:0] cpu_wdata,
   output logic              cpu_grant,
   output logic              cpu_ack,
   input  logic              brk_req,
   input  logic [ADDR_W-1:0] brk_addr,
   input  logic              brk_wr,
   input  logic [WORD_W-1:0] brk_wdata,
   output logic              brk_grant,
   output logic              brk_ack,
   output logic [WORD_W-1:0] rdata,
   output logic              rdata_valid,
   output logic              timeout_err,
   output logic              mem_start,
   input  logic              mem_done_n,
   input  logic              strobe_n,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_data_in,
   input  logic [WORD_W-1:0] mem_data_out
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);

   mem_state_e        state_q, state_d;
   mem_owner_e        owner_q, owner_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              armed_q, armed_d;
   logic              seen_q, seen_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;
   logic              start_q, start_d;
   logic              cpu_grant_q, cpu_grant_d, brk_grant_q, brk_grant_d;
   logic              cpu_ack_q, cpu_ack_d, brk_ack_q, brk_ack_d;

   logic              grant_s, done_acc_s, expire_s, wd_run_s, wd_clear_s;

   // A low done is trusted only after a high level was seen this cycle
   assign grant_s    = (state_q == ST_IDLE) && (brk_req || cpu_req);
   assign done_acc_s = (state_q == ST_WAIT_DONE) && armed_q && !mem_done_n;
   assign wd_run_s   = (state_q == ST_WAIT_DONE) && !done_acc_s;
   assign wd_clear_s = (state_q == ST_START);

   mem_watchdog #(
      .TIMEOUT(TIMEOUT)
   ) u_watchdog (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (wd_clear_s),
      .run_i        (wd_run_s),
      .expire_o     (expire_s),
      .timeout_err_o(timeout_err)
   );

   // Next-state selection for the memory cycle sequence
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_s) state_d = ST_START;
            else         state_d = ST_IDLE;
         end
         ST_START: begin
            if (hold_q == HOLD_LAST) state_d = ST_WAIT_DONE;
            else                     state_d = ST_START;
         end
         ST_WAIT_DONE: begin
            if (done_acc_s || expire_s) state_d = ST_DONE;
            else                        state_d = ST_WAIT_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Latched request, handshake tracking and next values of all outputs
   always_comb begin
      owner_d = owner_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      if (state_q == ST_IDLE) begin
         if (brk_req) begin
            owner_d = OWN_BRK;
            addr_d  = brk_addr;
            wr_d    = brk_wr;
            wdata_d = brk_wdata;
         end else if (cpu_req) begin
            owner_d = OWN_CPU;
            addr_d  = cpu_addr;
            wr_d    = cpu_wr;
            wdata_d = cpu_wdata;
         end else begin
            owner_d = owner_q;
         end
      end else if (state_q == ST_DONE) begin
         owner_d = OWN_CPU;
         addr_d  = '0;
         wr_d    = 1'b0;
         wdata_d = '0;
      end else begin
         owner_d = owner_q;
      end

      hold_d = (state_q == ST_START) ? (hold_q + HOLD_W'(1)) : '0;

      armed_d = armed_q;
      if (grant_s) begin
         armed_d = 1'b0;
      end else if (((state_q == ST_START) || (state_q == ST_WAIT_DONE)) && mem_done_n) begin
         armed_d = 1'b1;
      end else begin
         armed_d = armed_q;
      end

      seen_d   = seen_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if (grant_s) begin
         seen_d = 1'b0;
      end else if ((state_q == ST_WAIT_DONE) && !strobe_n && !seen_q) begin
         seen_d   = 1'b1;
         rdata_d  = mem_data_out;
         rvalid_d = 1'b1;
      end else begin
         seen_d = seen_q;
      end

      start_d     = (state_d == ST_START);
      cpu_grant_d = (state_d != ST_IDLE) && (owner_d == OWN_CPU);
      brk_grant_d = (state_d != ST_IDLE) && (owner_d == OWN_BRK);
      cpu_ack_d   = (state_d == ST_DONE) && (owner_d == OWN_CPU);
      brk_ack_d   = (state_d == ST_DONE) && (owner_d == OWN_BRK);
   end

   // State and output registers; reset aborts any cycle in flight
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWN_CPU;
         addr_q      <= '0;
         wr_q        <= 1'b0;
         wdata_q     <= '0;
         hold_q      <= '0;
         armed_q     <= 1'b0;
         seen_q      <= 1'b0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         start_q     <= 1'b0;
         cpu_grant_q <= 1'b0;
         brk_grant_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         brk_ack_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         addr_q      <= addr_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         hold_q      <= hold_d;
         armed_q     <= armed_d;
         seen_q      <= seen_d;
         rdata_q     <= rdata_d;
         rvalid_q    <= rvalid_d;
         start_q     <= start_d;
         cpu_grant_q <= cpu_grant_d;
         brk_grant_q <= brk_grant_d;
         cpu_ack_q   <= cpu_ack_d;
         brk_ack_q   <= brk_ack_d;
      end
   end

   // Reads write back what was just read (core restore)
   assign mem_data_in = wr_q ? wdata_q : mem_data_out;
   assign mem_addr    = addr_q;
   assign mem_start   = start_q;
   assign rdata       = rdata_q;
   assign rdata_valid = rvalid_q;
   assign cpu_grant   = cpu_grant_q;
   assign brk_grant   = brk_grant_q;
   assign cpu_ack     = cpu_ack_q;
   assign brk_ack     = brk_ack_q;

endmodule

// File: tb/tb_mem_ctl.sv
// Directed bench for mem_ctl with a behavioural core memory model.
module tb_mem_ctl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_req = 1'b0, cpu_wr = 1'b0, brk_req = 1'b0, brk_wr = 1'b0;
   logic [14:0] cpu_addr = 15'd0, brk_addr = 15'd0;
   logic [11:0] cpu_wdata = 12'd0, brk_wdata = 12'd0;
   logic        cpu_grant, cpu_ack, brk_grant, brk_ack;
   logic [11:0] rdata;
   logic        rdata_valid, timeout_err, mem_start, mem_done_n, strobe_n;
   logic [14:0] mem_addr;
   logic [11:0] mem_data_in, mem_data_out;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int ack_cnt = 0;

   // memory model state
   logic [11:0] mem_arr [0:32767];
   logic        prev_start = 1'b0;
   logic        active = 1'b0;
   int          k = 0;
   logic [14:0] addr_l = 15'd0;
   logic [11:0] dout_r = 12'd0;
   logic        force_hi = 1'b0, force_lo = 1'b0;
   logic        pl_en = 1'b0;
   logic [14:0] pl_addr = 15'd0;
   logic [11:0] pl_data = 12'd0;

   mem_ctl #(.START_HOLD(4), .TIMEOUT(200)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
      .cpu_grant(cpu_grant), .cpu_ack(cpu_ack),
      .brk_req(brk_req), .brk_addr(brk_addr), .brk_wr(brk_wr), .brk_wdata(brk_wdata),
      .brk_grant(brk_grant), .brk_ack(brk_ack),
      .rdata(rdata), .rdata_valid(rdata_valid), .timeout_err(timeout_err),
      .mem_start(mem_start), .mem_done_n(mem_done_n), .strobe_n(strobe_n),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (cpu_ack || brk_ack) ack_cnt <= ack_cnt + 1;
   end

   // Core memory: timer k counts from the mem_start rising edge
   always @(posedge clk) begin
      prev_start <= mem_start;
      if (pl_en) mem_arr[pl_addr] <= pl_data;
      if (mem_start && !prev_start) begin
         active <= 1'b1;
         k      <= 1;
         addr_l <= mem_addr;
      end else if (active) begin
         if (k == 30) dout_r <= mem_arr[addr_l];
         if (k == 80) mem_arr[addr_l] <= mem_data_in;
         if (k < 1000) k <= k + 1;
      end
   end

   assign strobe_n     = !(active && k >= 50 && k <= 59);
   assign mem_done_n   = force_lo ? 1'b0 : (force_hi ? 1'b1 : !(active && k >= 149));
   assign mem_data_out = dout_r;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic preload(input logic [14:0] a, input logic [11:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   // One transaction; times are cycle labels relative to the request edge R
   task automatic do_cycle(input logic brk, input logic [14:0] a, input logic wr,
                           input logic [11:0] wd, output int ts, output int tv,
                           output int ta, output int hi, output logic [11:0] rd);
      int r;
      int lbl;
      @(negedge clk);
      if (brk) begin brk_req = 1'b1; brk_addr = a; brk_wr = wr; brk_wdata = wd; end
      else     begin cpu_req = 1'b1; cpu_addr = a; cpu_wr = wr; cpu_wdata = wd; end
      r = cyc + 1;
      ts = -1; tv = -1; ta = -1; hi = 0; rd = 12'd0;
      for (int i = 0; i < 400 && ta < 0; i++) begin
         @(negedge clk);
         lbl = cyc + 1 - r;
         if (brk_grant) brk_req = 1'b0;
         if (cpu_grant) cpu_req = 1'b0;
         if (mem_start) begin hi++; if (ts < 0) ts = lbl; end
         if (rdata_valid && tv < 0) begin tv = lbl; rd = rdata; end
         if (brk ? brk_ack : cpu_ack) ta = lbl;
      end
      cpu_req = 1'b0; brk_req = 1'b0;
   endtask

   initial begin
      int ts, tv, ta, hi, r, lbl, rise1, rise2, ba, ca, cg, bcnt, viol, a3, acks0;
      logic [11:0] rd;
      logic ms_prev;

      repeat (3) @(negedge clk);
      check_val("reset_outs", {mem_start, cpu_grant, brk_grant, cpu_ack, brk_ack,
                               rdata_valid, timeout_err}, 32'd0);
      check_val("reset_addr_rdata", {mem_addr, rdata}, 32'd0);
      rst_n = 1'b1;
      preload(15'o00200, 12'o1234);
      preload(15'o17777, 12'o4321);
      preload(15'o00010, 12'o0011);
      preload(15'o07754, 12'o0022);

      // CPU read with restore
      do_cycle(1'b0, 15'o00200, 1'b0, 12'o0, ts, tv, ta, hi, rd);
      check_val("rd_start", ts, 1);
      check_val("rd_hold", hi, 4);
      check_val("rd_valid_t", tv, 52);
      check_val("rd_data", rd, 12'o1234);
      check_val("rd_ack_t", ta, 151);
      check_val("rd_restore", mem_arr[15'o00200], 12'o1234);

      // CPU write, then read back
      do_cycle(1'b0, 15'o17777, 1'b1, 12'o7070, ts, tv, ta, hi, rd);
      check_val("wr_ack_t", ta, 151);
      check_val("wr_old_data", rd, 12'o4321);
      check_val("wr_mem", mem_arr[15'o17777], 12'o7070);
      do_cycle(1'b0, 15'o17777, 1'b0, 12'o0, ts, tv, ta, hi, rd);
      check_val("wr_readback", rd, 12'o7070);

      // Simultaneous requests: break first
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = 15'o00010; cpu_wr = 1'b0;
      brk_req = 1'b1; brk_addr = 15'o07754; brk_wr = 1'b0;
      r = cyc + 1;
      rise1 = -1; rise2 = -1; ba = -1; ca = -1; cg = -1; ms_prev = 1'b0;
      for (int i = 0; i < 400 && ca < 0; i++) begin
         @(negedge clk);
         lbl = cyc + 1 - r;
         if (brk_grant) brk_req = 1'b0;
         if (cpu_grant) begin cpu_req = 1'b0; if (cg < 0) cg = lbl; end
         if (mem_start && !ms_prev) begin
            if (rise1 < 0) rise1 = lbl;
            else if (rise2 < 0) rise2 = lbl;
         end
         ms_prev = mem_start;
         if (brk_ack && ba < 0) ba = lbl;
         if (cpu_ack && ca < 0) ca = lbl;
      end
      cpu_req = 1'b0; brk_req = 1'b0;
      check_val("sim_brk_ack_t", ba, 151);
      check_val("sim_rise1", rise1, 1);
      check_val("sim_rise2_window", (rise2 >= 153 && rise2 <= 154) ? 1 : 0, 1);
      check_val("sim_cpu_grant_t", cg, rise2);
      check_val("sim_cpu_ack_t", ca, rise2 + 150);

      // done stuck high: watchdog completes the cycle
      check_val("tmo_err_before", timeout_err, 1'b0);
      force_hi = 1'b1;
      do_cycle(1'b0, 15'o00200, 1'b0, 12'o0, ts, tv, ta, hi, rd);
      force_hi = 1'b0;
      check_val("tmo_hi_ack_t", ta, 205);
      check_val("tmo_err_set", timeout_err, 1'b1);

      // done stuck low: never armed, so no early completion
      force_lo = 1'b1;
      do_cycle(1'b0, 15'o00200, 1'b0, 12'o0, ts, tv, ta, hi, rd);
      force_lo = 1'b0;
      check_val("tmo_lo_ack_t", ta, 205);
      check_val("tmo_err_sticky", timeout_err, 1'b1);

      // Reset in the middle of a write at S+70
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = 15'o17777; cpu_wr = 1'b1; cpu_wdata = 12'o5555;
      r = cyc + 1;
      acks0 = ack_cnt;
      while (cyc < r + 70) begin
         @(negedge clk);
         if (cpu_grant) cpu_req = 1'b0;
      end
      check_val("rst_mid_grant", cpu_grant, 1'b1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_val("rst_mid_outs", {mem_start, cpu_grant, brk_grant, cpu_ack, brk_ack}, 32'd0);
      check_val("rst_mid_err", timeout_err, 1'b0);
      check_val("rst_mid_addr", mem_addr, 15'd0);
      repeat (100) @(negedge clk);
      check_val("rst_no_ack", ack_cnt, acks0);
      check_val("rst_mem_kept", mem_arr[15'o17777], 12'o7070);
      do_cycle(1'b0, 15'o17777, 1'b0, 12'o0, ts, tv, ta, hi, rd);
      check_val("rst_next_data", rd, 12'o7070);
      check_val("rst_next_ack_t", ta, 151);

      // Continuous break for three cycles starves the CPU
      @(negedge clk);
      cpu_req = 1'b1; cpu_addr = 15'o00200; cpu_wr = 1'b0;
      brk_req = 1'b1; brk_addr = 15'o07754; brk_wr = 1'b0;
      r = cyc + 1;
      bcnt = 0; viol = 0; a3 = -1; cg = -1; ca = -1; rd = 12'd0;
      for (int i = 0; i < 900 && ca < 0; i++) begin
         @(negedge clk);
         lbl = cyc + 1 - r;
         if (cpu_grant && cg < 0) cg = lbl;
         if (cpu_grant && bcnt < 3) viol++;
         if (cpu_grant) cpu_req = 1'b0;
         if (cpu_grant && rdata_valid) rd = rdata;
         if (brk_ack) begin
            bcnt++;
            if (bcnt == 3) begin brk_req = 1'b0; a3 = lbl; end
         end
         if (cpu_ack && ca < 0) ca = lbl;
      end
      cpu_req = 1'b0; brk_req = 1'b0;
      check_val("starve_no_cpu", viol, 0);
      check_val("starve_brk_cnt", bcnt, 3);
      check_val("starve_cpu_grant_t", cg, a3 + 2);
      check_val("starve_cpu_ack_t", ca, cg + 150);
      check_val("starve_cpu_data", rd, 12'o1234);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
